tx_frame_arbiter: RTL and testbench
===================================

# tx_frame_arbiter

Round-robin scheduler that shares one serial frame `transmitter` between NREQ frame sources. It latches the winning source's payload, drives the transmitter's `tf`/`framesize`/`framebits`/`baudrate` inputs, and tracks the transmitter's `TXI` idle flag to detect start and completion. It returns per-source grant, done and error pulses. It sits between the frame producers and the transmitter, and owns the baud-rate configuration register.

## Interface
- NREQ, 4, number of requesters (2..8)
- START_TO, 4, max cycles `tf` is held waiting for `TXI` to fall
- BAUD_DEFAULT, 8'd16, baudrate after reset
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  NREQ  level request per source
- req_size  in  4*NREQ  source i frame size in bytes at bits [4i+3:4i]
- req_bits  in  128*NREQ  source i payload at bits [128i+127:128i]
- baud_in  in  8  new baud divisor
- baud_we  in  1  baud write strobe
- TXI  in  1  transmitter idle flag (1 = idle)
- tf  out  1  transmit-frame strobe to transmitter
- framesize  out  4  latched size to transmitter
- framebits  out  128  latched payload to transmitter
- baudrate  out  8  current divisor to transmitter
- gnt  out  NREQ  one-hot 1-cycle pulse: payload accepted
- done  out  NREQ  one-hot 1-cycle pulse: frame finished
- err  out  NREQ  one-hot 1-cycle pulse: rejected or start timeout
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, BUSY.
- IDLE
  - Arbitration is eligible only when `TXI`==1 and `req`!=0.
  - Winner is the first set `req` bit scanning upward from `ptr`, wrapping modulo NREQ.
  - On arbitration, `ptr` <= winner+1 (mod NREQ).
- Winner with size 0
  - `err[w]` pulses.
  - No `tf`, no `gnt`. Stay in IDLE.
- Winner with size != 0
  - `gnt[w]` pulses.
  - `framesize`/`framebits` <= source w payload, and hold until the next grant.
  - `tf` <= 1, state <= START, `cur` <= w, `to_cnt` <= 0.
- START
  - `tf` stays 1.
  - If `TXI`==0: `tf` <= 0, state <= BUSY.
  - Else if `to_cnt`==START_TO-1: `tf` <= 0, `err[cur]` pulses, state <= IDLE.
  - Otherwise `to_cnt` increments.
- BUSY: when `TXI`==1, `done[cur]` pulses and state <= IDLE.
- Requester rules
  - Hold `req` and payload stable until `gnt` or `err`.
  - Drop `req` in the cycle after the pulse to avoid being re-served.
  - A request still asserted is served again only after the round-robin pass.
- Baud register
  - `baud_we` with `baud_in` < 2 is ignored (transmitter needs ≥ 2).
  - In IDLE, a valid write sets `baudrate` <= `baud_in` on the next edge.
  - In START/BUSY, a valid write is stored as pending (the last write wins). It is applied on the edge that enters IDLE.
  - `baudrate` never changes while a frame is in flight.
- Simultaneous events
  - `baud_we` in the same IDLE cycle as a grant: the new baud applies on the same edge as `tf`, so the frame uses the new value.
  - `done` pulse and a new grant never coincide; the earliest new grant is the edge after `done`.

## Timing
- Reset values: state IDLE, `ptr` 0, `tf` 0, `gnt`/`done`/`err` 0, `framesize` 0, `framebits` 0, `baudrate` BAUD_DEFAULT, pending baud cleared, `busy` 0.
- Reset mid-frame
  - All registers return to reset values.
  - The transmitter has no reset and may still be busy. IDLE requires `TXI`==1 before granting, so there is no collision.
  - No `done` is issued for the aborted frame.
- Request to grant: `req` sampled at edge N, so `gnt`, `tf` and payload are valid after edge N+1 (1 cycle).
- `tf` holds ≥ 1 cycle.
  - Nominal hold is 2 cycles: the transmitter drops `TXI` one edge after sampling `tf`, and the arbiter sees it the edge after that.
  - Maximum hold is START_TO cycles.
- `done` follows the `TXI` rising edge by 1 cycle. The earliest re-grant is the cycle after `done`.
- `busy` is registered with state.

## Test plan
- Single request: NREQ=4, `req`=0001, size 2, `TXI` model busy for 60 cycles. Required: `gnt`=0001 at cycle 1; `tf` high for 2 cycles; `framesize`=2; `done`=0001 one cycle after `TXI` rises; `busy` low after.
- Round-robin fairness: `req`=1111 held continuously, all sizes 1. Grant order is 0,1,2,3,0; each grant follows the previous `done` by one cycle.
- Zero size: `req`=0100 with size 0. Required: `err`=0100 one cycle later; `tf` stays 0; `ptr`=3.
- Start timeout: `TXI` stuck at 1, `req`=0010 with size 3, START_TO=4. Required: `tf` high for exactly 4 cycles, then `err`=0010 and state IDLE.
- Baud deferral: write 8'd9 in IDLE, and `baudrate`=9 on the next cycle. Write 8'd20 while BUSY, and `baudrate` stays 9 until `done`, then becomes 20. Write 8'd1 and it is ignored.
- Reset mid-BUSY with `TXI`=0 and `req`=0001 re-asserted: all outputs go to reset values. No `gnt` until `TXI` returns to 1, then `gnt`=0001.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin scheduler that shares one serial frame transmitter
// between NREQ sources and owns the transmitter's baud-rate register.
module tx_frame_arbiter #(
   parameter int         NREQ         = 4,
   parameter int         START_TO     = 4,
   parameter logic [7:0] BAUD_DEFAULT = 8'd16
) (
   input  logic                   clk,
   input  logic                   reset,
   // Handshake: req[i] is a level request. Source i holds req[i] and its payload
   // stable until a one-cycle gnt[i] (accepted) or err[i] (rejected) pulse, then
   // drops req[i] in the following cycle unless it wants another frame.
   input  logic [NREQ-1:0]        req,
   input  logic [4*NREQ-1:0]      req_size,
   input  logic [128*NREQ-1:0]    req_bits,
   input  logic [7:0]             baud_in,
   input  logic                   baud_we,
   input  logic                   TXI,
   output logic                   tf,
   output logic [3:0]             framesize,
   output logic [127:0]           framebits,
   output logic [7:0]             baudrate,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic [NREQ-1:0]        err,
   output logic                   busy,
   output logic [1:0]             state_dbg
);

   localparam int             PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int             TW      = $clog2(START_TO + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(START_TO - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   cur;
   logic [TW-1:0]   to_cnt;
   logic            pend_vld;
   logic [7:0]      pend_val;

   logic [PW-1:0]   idx;
   logic [PW-1:0]   win;
   logic [PW-1:0]   ptr_nxt;
   logic            win_vld;
   logic [3:0]      win_size;
   logic [127:0]    win_bits;
   logic            baud_ok;
   logic            leave;

   assign state_dbg = state;
   assign baud_ok   = baud_we && (baud_in >= 8'd2);
   assign ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

   // Edge on which an in-flight frame ends (timeout or completion) and IDLE is re-entered.
   assign leave = ((state == S_START) && TXI && (to_cnt == TO_LAST)) ||
                  ((state == S_BUSY) && TXI);

   always_comb begin
      idx     = '0;
      win     = '0;
      win_vld = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!win_vld && req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      win_size = '0;
      win_bits = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            win_size = req_size[4*i +: 4];
            win_bits = req_bits[128*i +: 128];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ptr       <= '0;
         cur       <= '0;
         to_cnt    <= '0;
         tf        <= 1'b0;
         gnt       <= '0;
         done      <= '0;
         err       <= '0;
         framesize <= '0;
         framebits <= '0;
         baudrate  <= BAUD_DEFAULT;
         pend_vld  <= 1'b0;
         pend_val  <= '0;
         busy      <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= '0;
         err  <= '0;
         case (state)
            S_IDLE: begin
               if (baud_ok)
                  baudrate <= baud_in;
               if (TXI && win_vld) begin
                  ptr <= ptr_nxt;
                  if (win_size == 4'd0) begin
                     err <= NREQ'(1) << win;
                  end else begin
                     gnt       <= NREQ'(1) << win;
                     framesize <= win_size;
                     framebits <= win_bits;
                     tf        <= 1'b1;
                     cur       <= win;
                     to_cnt    <= '0;
                     state     <= S_START;
                     busy      <= 1'b1;
                  end
               end
            end
            S_START: begin
               if (!TXI) begin
                  tf    <= 1'b0;
                  state <= S_BUSY;
               end else if (to_cnt == TO_LAST) begin
                  tf    <= 1'b0;
                  err   <= NREQ'(1) << cur;
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_BUSY: begin
               if (TXI) begin
                  done  <= NREQ'(1) << cur;
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               tf    <= 1'b0;
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase

         // Baud writes during a frame are parked and land on the edge that re-enters IDLE.
         if (state != S_IDLE) begin
            if (leave) begin
               if (baud_ok)
                  baudrate <= baud_in;
               else if (pend_vld)
                  baudrate <= pend_val;
               pend_vld <= 1'b0;
            end else if (baud_ok) begin
               pend_vld <= 1'b1;
               pend_val <= baud_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_tx_frame_arbiter;

   localparam int         NREQ         = 4;
   localparam int         START_TO     = 4;
   localparam logic [7:0] BAUD_DEFAULT = 8'd16;
   localparam int         PW           = 2;
   localparam int         EW           = 3*NREQ + 2 + 8 + 4 + 128;

   // ---------------- clock / reset / DUT ----------------
   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [4*NREQ-1:0]     req_size;
   logic [128*NREQ-1:0]   req_bits;
   logic [7:0]            baud_in;
   logic                  baud_we;
   logic                  TXI;
   logic                  tf;
   logic [3:0]            framesize;
   logic [127:0]          framebits;
   logic [7:0]            baudrate;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       err;
   logic                  busy;
   logic [1:0]            state_dbg;

   logic [3:0]            src_size [NREQ];
   logic [127:0]          src_bits [NREQ];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_size[4*gi +: 4]     = src_size[gi];
      assign req_bits[128*gi +: 128] = src_bits[gi];
   end

   tx_frame_arbiter #(
      .NREQ(NREQ), .START_TO(START_TO), .BAUD_DEFAULT(BAUD_DEFAULT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_size(req_size), .req_bits(req_bits),
      .baud_in(baud_in), .baud_we(baud_we), .TXI(TXI), .tf(tf), .framesize(framesize),
      .framebits(framebits), .baudrate(baudrate), .gnt(gnt), .done(done), .err(err),
      .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- scoreboard / reference model ----------------
   int              n_vec  = 0;
   int              n_miss = 0;
   int              cyc    = 0;
   logic [EW-1:0]   exp_q[$];

   int              m_ptr, m_owner, m_wait, m_pend;
   bit              m_started;
   logic            m_tf;
   logic [7:0]      m_baud;
   logic [3:0]      m_fs;
   logic [127:0]    m_fb;

   int              gnt_log[$], gnt_cyc[$], gnt_rise[$];
   int              err_log[$], err_cyc[$];
   int              done_log[$], done_cyc[$];
   int              tf_hi;
   logic [7:0]      baud_at_done;

   // environment knobs and transmitter model
   bit              auto_req, drop_on_pulse, tx_stuck, tx_rand;
   int              tx_len, tx_cnt, txi_rise_cyc;
   logic            tf_prev;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
      end
   endtask

   task automatic model_step();
      logic [NREQ-1:0] g, d, e;
      logic            bsy;
      bit              bw_ok;
      int              w, x;
      g = '0; d = '0; e = '0;
      bw_ok = baud_we && (baud_in >= 8'd2);
      if (reset) begin
         m_ptr = 0; m_owner = -1; m_wait = 0; m_pend = -1; m_started = 0;
         m_tf = 1'b0; m_baud = BAUD_DEFAULT; m_fs = '0; m_fb = '0;
      end else if (m_owner < 0) begin
         if (bw_ok) m_baud = baud_in;
         if (TXI && req != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
               x = (m_ptr + k) % NREQ;
               if (w < 0 && req[PW'(x)]) w = x;
            end
            m_ptr = (w + 1) % NREQ;
            if (src_size[w] == 4'd0) begin
               e[PW'(w)] = 1'b1;
            end else begin
               g[PW'(w)] = 1'b1;
               m_fs = src_size[w]; m_fb = src_bits[w];
               m_owner = w; m_started = 0; m_wait = 0; m_tf = 1'b1;
            end
         end
      end else begin
         if (bw_ok) m_pend = int'(baud_in);
         if (!m_started) begin
            if (!TXI) begin
               m_started = 1; m_tf = 1'b0;
            end else if (m_wait == START_TO - 1) begin
               m_tf = 1'b0;
               e[PW'(m_owner)] = 1'b1;
               if (m_pend >= 0) m_baud = 8'(m_pend);
               m_pend = -1; m_owner = -1;
            end else begin
               m_wait++;
            end
         end else if (TXI) begin
            d[PW'(m_owner)] = 1'b1;
            if (m_pend >= 0) m_baud = 8'(m_pend);
            m_pend = -1; m_owner = -1;
         end
      end
      bsy = (m_owner >= 0);
      exp_q.push_back({g, d, e, m_tf, bsy, m_baud, m_fs, m_fb});
   endtask

   task automatic new_payload(input int i, input logic [3:0] sz);
      src_size[i] = sz;
      src_bits[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      logic [EW-1:0]   ev;
      logic [NREQ-1:0] e_gnt, e_done, e_err;
      logic            e_tf, e_busy;
      logic [7:0]      e_baud;
      logic [3:0]      e_fs;
      logic [127:0]    e_fb;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      ev = exp_q.pop_front();
      {e_gnt, e_done, e_err, e_tf, e_busy, e_baud, e_fs, e_fb} = ev;
      check_eq("gnt",       128'(gnt),       128'(e_gnt));
      check_eq("done",      128'(done),      128'(e_done));
      check_eq("err",       128'(err),       128'(e_err));
      check_eq("tf",        128'(tf),        128'(e_tf));
      check_eq("busy",      128'(busy),      128'(e_busy));
      check_eq("baudrate",  128'(baudrate),  128'(e_baud));
      check_eq("framesize", 128'(framesize), 128'(e_fs));
      check_eq("framebits", framebits,       e_fb);
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i])  begin gnt_log.push_back(i);  gnt_cyc.push_back(cyc); gnt_rise.push_back(txi_rise_cyc); end
         if (err[i])  begin err_log.push_back(i);  err_cyc.push_back(cyc);  end
         if (done[i]) begin done_log.push_back(i); done_cyc.push_back(cyc); baud_at_done = baudrate; end
      end
      if (tf) tf_hi++;
      // transmitter: drops TXI one edge after sampling tf, stays busy tx_cnt cycles
      if (TXI) begin
         if (tf_prev && !tx_stuck) begin
            TXI = 1'b0;
            tx_cnt = tx_rand ? int'($urandom_range(1, 12)) : tx_len;
         end
      end else if (tx_cnt == 0) begin
         TXI = 1'b1;
         txi_rise_cyc = cyc;
      end else begin
         tx_cnt--;
      end
      tf_prev = tf;
      // requesters
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && (gnt[i] || err[i]) && drop_on_pulse)
            req[i] = 1'b0;
         else if (auto_req && !req[i] && $urandom_range(0, 3) == 0) begin
            new_payload(i, 4'($urandom_range(0, 15)));
            req[i] = 1'b1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_logs();
      gnt_log.delete(); gnt_cyc.delete(); gnt_rise.delete();
      err_log.delete(); err_cyc.delete();
      done_log.delete(); done_cyc.delete();
      tf_hi = 0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      reset = 1'b1; req = '0; baud_in = '0; baud_we = 1'b0; TXI = 1'b1;
      for (int i = 0; i < NREQ; i++) begin src_size[i] = '0; src_bits[i] = '0; end
      auto_req = 0; drop_on_pulse = 1; tx_stuck = 0; tx_rand = 0; tx_len = 5;
      tx_cnt = 0; txi_rise_cyc = 0; tf_prev = 1'b0; baud_at_done = '0;
      clear_logs();
      run(2);
      check_eq("rst_state", 128'(state_dbg), 128'(0));
      reset = 1'b0;

      // single request, long transmission
      clear_logs(); t0 = cyc; tx_len = 60;
      new_payload(0, 4'd2); req = 4'b0001;
      run(75);
      check_eq("t1_ngnt", 128'(gnt_log.size()), 128'(1));
      if (gnt_log.size() > 0) check_eq("t1_gnt_lat", 128'(gnt_cyc[0] - t0), 128'(1));
      check_eq("t1_tf_len", 128'(tf_hi), 128'(2));
      check_eq("t1_ndone", 128'(done_log.size()), 128'(1));
      if (done_log.size() > 0) check_eq("t1_done_lat", 128'(done_cyc[0] - txi_rise_cyc), 128'(1));
      check_eq("t1_busy_end", 128'(busy), 128'(0));

      // round-robin with all requests held
      pulse_reset();
      clear_logs(); tx_len = 3; drop_on_pulse = 0;
      for (int i = 0; i < NREQ; i++) new_payload(i, 4'd1);
      req = 4'b1111;
      run(60);
      req = '0; drop_on_pulse = 1;
      run(20);
      check_eq("t2_ngnt_ge5", 128'(gnt_log.size() >= 5), 128'(1));
      for (int k = 0; k < 5; k++)
         if (k < gnt_log.size()) check_eq("t2_order", 128'(gnt_log[k]), 128'(k % NREQ));
      for (int k = 0; k < 4; k++)
         if (k + 1 < gnt_cyc.size() && k < done_cyc.size())
            check_eq("t2_regrant_gap", 128'(gnt_cyc[k+1] - done_cyc[k]), 128'(1));

      // zero-size request, then pointer position
      pulse_reset();
      clear_logs(); t0 = cyc;
      new_payload(2, 4'd0); req = 4'b0100;
      run(3);
      check_eq("t3_nerr", 128'(err_log.size()), 128'(1));
      if (err_log.size() > 0) begin
         check_eq("t3_err_src", 128'(err_log[0]), 128'(2));
         check_eq("t3_err_lat", 128'(err_cyc[0] - t0), 128'(1));
      end
      check_eq("t3_no_tf", 128'(tf_hi), 128'(0));
      check_eq("t3_no_gnt", 128'(gnt_log.size()), 128'(0));
      new_payload(0, 4'd1); new_payload(1, 4'd1); new_payload(3, 4'd1);
      req = 4'b1011;
      run(2);
      if (gnt_log.size() > 0) check_eq("t3_ptr_next", 128'(gnt_log[0]), 128'(3));
      else check_eq("t3_ptr_next_gnt", 128'(0), 128'(1));
      req = '0;
      run(20);

      // start timeout with transmitter stuck idle
      clear_logs(); t0 = cyc; tx_stuck = 1;
      new_payload(1, 4'd3); req = 4'b0010;
      run(8);
      check_eq("t4_tf_len", 128'(tf_hi), 128'(START_TO));
      check_eq("t4_nerr", 128'(err_log.size()), 128'(1));
      if (err_log.size() > 0) begin
         check_eq("t4_err_src", 128'(err_log[0]), 128'(1));
         check_eq("t4_err_lat", 128'(err_cyc[0] - t0), 128'(1 + START_TO));
      end
      check_eq("t4_idle", 128'(state_dbg), 128'(0));
      tx_stuck = 0;

      // baud register deferral
      clear_logs(); tx_len = 20;
      baud_in = 8'd9; baud_we = 1'b1; cycle(); baud_we = 1'b0;
      check_eq("t5_baud_idle", 128'(baudrate), 128'(9));
      new_payload(0, 4'd1); req = 4'b0001;
      run(6);
      baud_in = 8'd20; baud_we = 1'b1; cycle(); baud_we = 1'b0;
      check_eq("t5_baud_held", 128'(baudrate), 128'(9));
      run(30);
      check_eq("t5_ndone", 128'(done_log.size()), 128'(1));
      check_eq("t5_baud_at_done", 128'(baud_at_done), 128'(20));
      baud_in = 8'd1; baud_we = 1'b1; cycle(); baud_we = 1'b0;
      check_eq("t5_baud_ignored", 128'(baudrate), 128'(20));
      new_payload(3, 4'd5); req = 4'b1000;
      baud_in = 8'd30; baud_we = 1'b1; cycle(); baud_we = 1'b0;
      check_eq("t5_same_gnt", 128'(gnt), 128'(4'b1000));
      check_eq("t5_same_baud", 128'(baudrate), 128'(30));
      run(30);

      // reset in the middle of a frame with the transmitter still busy
      clear_logs(); tx_len = 30;
      new_payload(0, 4'd2); req = 4'b0001;
      run(6);
      check_eq("t6_busy_pre", 128'(busy), 128'(1));
      reset = 1'b1; req = 4'b0001; cycle(); reset = 1'b0;
      check_eq("t6_rst_busy", 128'(busy), 128'(0));
      check_eq("t6_rst_size", 128'(framesize), 128'(0));
      clear_logs();
      run(40);
      check_eq("t6_ngnt", 128'(gnt_log.size()), 128'(1));
      if (gnt_log.size() > 0) begin
         check_eq("t6_gnt_src", 128'(gnt_log[0]), 128'(0));
         check_eq("t6_gnt_after_txi", 128'(gnt_cyc[0] - gnt_rise[0]), 128'(1));
      end
      check_eq("t6_no_done", 128'(done_log.size()), 128'(0));
      run(50);

      // randomized traffic
      pulse_reset();
      auto_req = 1; tx_rand = 1;
      for (int n = 0; n < 1500; n++) begin
         if (n % 64 == 0) tx_stuck = ($urandom_range(0, 3) == 0);
         baud_we = ($urandom_range(0, 9) == 0);
         baud_in = 8'($urandom_range(0, 40));
         reset = ($urandom_range(0, 399) == 0);
         cycle();
      end
      reset = 1'b0; baud_we = 1'b0; auto_req = 0; req = '0; tx_stuck = 0;
      run(100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
